// File: rtl/iter_mdu_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface iter_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, in1, in2, cancel, input hi, lo, busy, done);
  modport slave  (input start, op, in1, in2, cancel, output hi, lo, busy, done);
endinterface

// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit: radix-MUL_K shift-add multiplier, restoring divider,
// HI/LO ownership with accumulate, flush and a completion pulse.
module iter_mdu #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MUL_K  = 1,
  parameter int unsigned ACC_EN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  iter_mdu_if.slave  bus
);
  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_K - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DW-1:0]    mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d, orig_q, orig_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             acc_add_q, acc_add_d, acc_sub_q, acc_sub_d;

  logic             legal, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [DW-1:0]    partial, res;
  logic [WIDTH:0]   top, diff;

  always_comb begin
    state_d   = state_q;   cnt_d     = cnt_q;
    hi_d      = hi_q;      lo_d      = lo_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;   prod_d    = prod_q;
    mplier_d  = mplier_q;  orig_d    = orig_q;
    is_div_d  = is_div_q;  neg_d     = neg_q;
    rneg_d    = rneg_q;    dz_d      = dz_q;
    acc_add_d = acc_add_q; acc_sub_d = acc_sub_q;

    unique case (bus.op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: legal = 1'b1;
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:                 legal = (ACC_EN != 0);
      default:                                              legal = 1'b0;
    endcase
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    a_neg = signed_op && bus.in1[WIDTH-1];
    b_neg = signed_op && bus.in2[WIDTH-1];
    a_mag = a_neg ? WIDTH'(0) - bus.in1 : bus.in1;
    b_mag = b_neg ? WIDTH'(0) - bus.in2 : bus.in2;

    // One multiplier step retires MUL_K bits of the multiplier
    partial = '0;
    for (int j = 0; j < int'(MUL_K); j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end

    // One restoring-division step on {rem, quo} held in prod_q
    top  = prod_q[DW-1:WIDTH-1];
    diff = top - {1'b0, mplier_q};

    res   = neg_q ? DW'(0) - prod_q : prod_q;
    q_fix = neg_q ? WIDTH'(0) - prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    r_fix = rneg_q ? WIDTH'(0) - prod_q[DW-1:WIDTH] : prod_q[DW-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel && legal) begin
          if (bus.op == OP_MTHI) begin
            hi_d = bus.in1;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.in1;
          end else begin
            cnt_d     = '0;
            orig_d    = bus.in1;
            mplier_d  = b_mag;
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
            dz_d      = (bus.in2 == '0);
            is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
            acc_add_d = (bus.op == OP_MADD) || (bus.op == OP_MADDU);
            acc_sub_d = (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
            mcand_d   = {WIDTH'(0), a_mag};
            if (is_div_d) begin
              prod_d  = {WIDTH'(0), a_mag};
              state_d = S_DIV;
            end else begin
              prod_d  = '0;
              state_d = S_MUL;
            end
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_q + partial;
        mcand_d  = mcand_q << MUL_K;
        mplier_d = mplier_q >> MUL_K;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) state_d = S_FIX;
      end
      S_DIV: begin
        if (!diff[WIDTH]) prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else              prod_d = {top[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      default: begin
        if (is_div_q) begin
          hi_d = dz_q ? orig_q : r_fix;
          lo_d = dz_q ? '1 : q_fix;
        end else if (acc_add_q) begin
          {hi_d, lo_d} = {hi_q, lo_q} + res;
        end else if (acc_sub_q) begin
          {hi_d, lo_d} = {hi_q, lo_q} - res;
        end else begin
          {hi_d, lo_d} = res;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Flush beats everything, including the write in the final cycle
    if (state_q != S_IDLE && bus.cancel) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;   cnt_q    <= '0;
      hi_q    <= '0;       lo_q     <= '0;
      busy_q  <= 1'b0;     done_q   <= 1'b0;
      mcand_q <= '0;       prod_q   <= '0;
      mplier_q <= '0;      orig_q   <= '0;
      is_div_q <= 1'b0;    neg_q    <= 1'b0;
      rneg_q  <= 1'b0;     dz_q     <= 1'b0;
      acc_add_q <= 1'b0;   acc_sub_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q    <= cnt_d;
      hi_q    <= hi_d;     lo_q     <= lo_d;
      busy_q  <= busy_d;   done_q   <= done_d;
      mcand_q <= mcand_d;  prod_q   <= prod_d;
      mplier_q <= mplier_d; orig_q  <= orig_d;
      is_div_q <= is_div_d; neg_q   <= neg_d;
      rneg_q  <= rneg_d;   dz_q     <= dz_d;
      acc_add_q <= acc_add_d; acc_sub_q <= acc_sub_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_iter_mdu.sv
// Scoreboard bench for iter_mdu: a radix-1 instance with accumulate and a radix-4 instance without.
module tb_iter_mdu;
  localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MADD = 4'd7, MSUBU = 4'd10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   cnt0 = 0;
  int   cnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  iter_mdu_if #(.WIDTH(32)) b0();
  iter_mdu_if #(.WIDTH(32)) b1();

  iter_mdu #(.WIDTH(32), .MUL_K(1), .ACC_EN(1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  iter_mdu #(.WIDTH(32), .MUL_K(4), .ACC_EN(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitors: pop the scoreboard on every done pulse and check data and busy length
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) cnt0 = 0;
    else if (b0.done) begin
      if (q0.size() == 0) chk("unexpected_done0", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        chk("hi0", 64'(b0.hi), 64'(e.hi));
        chk("lo0", 64'(b0.lo), 64'(e.lo));
        chk("lat0", 64'(cnt0), 64'(e.lat));
      end
      cnt0 = 0;
    end else if (b0.busy) cnt0++;
    else cnt0 = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) cnt1 = 0;
    else if (b1.done) begin
      if (q1.size() == 0) chk("unexpected_done1", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("hi1", 64'(b1.hi), 64'(e.hi));
        chk("lo1", 64'(b1.lo), 64'(e.lo));
        chk("lat1", 64'(cnt1), 64'(e.lat));
      end
      cnt1 = 0;
    end else if (b1.busy) cnt1++;
    else cnt1 = 0;
  end

  // Called at a negedge; start is held across exactly one rising edge
  task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] ehi,
                       input logic [31:0] elo, input int lat);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.lat = lat;
    if (sel) begin
      b1.start = 1'b1; b1.op = op; b1.in1 = a; b1.in2 = b;
      if (push) q1.push_back(e);
    end else begin
      b0.start = 1'b1; b0.op = op; b0.in1 = a; b0.in2 = b;
      if (push) q0.push_back(e);
    end
    @(negedge clk);
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sel ? b1.done : b0.done) seen = 1'b1;
    end
    chk("done_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    b0.start = 1'b0; b0.op = '0; b0.in1 = '0; b0.in2 = '0; b0.cancel = 1'b0;
    b1.start = 1'b0; b1.op = '0; b1.in1 = '0; b1.in2 = '0; b1.cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(b0.hi), 64'd0);
    chk("rst_lo", 64'(b0.lo), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(0, MULT, 32'hFFFFFFFE, 32'd3, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 33); wait_done(0);
    issue(0, DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);  wait_done(0);
    issue(0, DIVU, 32'hFFFFFFF9, 32'd2, 1, 32'h00000001, 32'h7FFFFFFC, 33); wait_done(0);
    issue(0, DIV, 32'h00001234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 33);  wait_done(0);
    issue(0, DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 33);  wait_done(0);

    issue(0, MTHI, 32'd5, 32'd0, 0, 32'd0, 32'd0, 0);
    chk("mthi_hi", 64'(b0.hi), 64'd5);
    chk("mthi_busy", 64'(b0.busy), 64'd0);
    issue(0, MTLO, 32'd13, 32'd0, 0, 32'd0, 32'd0, 0);
    chk("mtlo_lo", 64'(b0.lo), 64'd13);
    chk("mtlo_done", 64'(b0.done), 64'd0);
    issue(0, MSUBU, 32'd1, 32'd14, 1, 32'd4, 32'hFFFFFFFF, 33); wait_done(0);
    issue(0, MADD, 32'd2, 32'd3, 1, 32'd5, 32'd5, 33);           wait_done(0);

    issue(0, MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 32'h3FFFFFFF, 32'h00000001, 33); wait_done(0);
    issue(0, MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd0, 32'd1, 33);               wait_done(0);
    issue(0, MULTU, 32'd5, 32'd6, 1, 32'd0, 32'd30, 33); wait_done(0);
    issue(0, MULTU, 32'd7, 32'd8, 1, 32'd0, 32'd56, 33); wait_done(0);

    // Flush mid-multiply with a competing start
    issue(0, MTHI, 32'hA, 32'd0, 0, 32'd0, 32'd0, 0);
    issue(0, MTLO, 32'hB, 32'd0, 0, 32'd0, 32'd0, 0);
    issue(0, MULT, 32'd7, 32'd9, 0, 32'd0, 32'd0, 0);
    repeat (9) @(negedge clk);
    chk("cancel_pre_busy", 64'(b0.busy), 64'd1);
    b0.cancel = 1'b1; b0.start = 1'b1; b0.op = MULT;
    @(negedge clk);
    b0.cancel = 1'b0; b0.start = 1'b0;
    chk("cancel_busy", 64'(b0.busy), 64'd0);
    chk("cancel_hi", 64'(b0.hi), 64'hA);
    chk("cancel_lo", 64'(b0.lo), 64'hB);
    chk("cancel_done", 64'(b0.done), 64'd0);
    repeat (40) @(negedge clk);

    // Reset in the middle of a divide
    issue(0, DIV, 32'd100, 32'd7, 0, 32'd0, 32'd0, 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_hi", 64'(b0.hi), 64'd0);
    chk("mrst_lo", 64'(b0.lo), 64'd0);
    chk("mrst_busy", 64'(b0.busy), 64'd0);
    chk("mrst_done", 64'(b0.done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(0, 4'd11, 32'd3, 32'd4, 0, 32'd0, 32'd0, 0);
    chk("illegal_busy", 64'(b0.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("illegal_lo", 64'(b0.lo), 64'd0);

    issue(1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 9); wait_done(1);
    issue(1, MADD, 32'd2, 32'd3, 0, 32'd0, 32'd0, 0);
    chk("noacc_busy", 64'(b1.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("noacc_hi", 64'(b1.hi), 64'hFFFFFFFE);

    repeat (3) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
